// File: rtl/mi_seq_pkg.sv
// Shared definitions for the microsequencer: entry field layout, the built-in
// three-state graph that the table powers up with, and the step action type.
package mi_seq_pkg;

    localparam int MAX_E = 128;

    localparam logic [2:0] Y1  = 3'b100;
    localparam logic [2:0] Y2  = 3'b010;
    localparam logic [2:0] Y23 = 3'b011;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_STEP,
        ACT_RESTART
    } seq_act_e;

    // Entry layout, LSB upward: mi, seq_next, br_next, csel, inv, uncond, halt.
    function automatic int seq_lsb(int out_w);
        return out_w;
    endfunction

    function automatic int br_lsb(int out_w, int sw);
        return out_w + sw;
    endfunction

    function automatic int csel_lsb(int out_w, int sw);
        return out_w + 2 * sw;
    endfunction

    function automatic int inv_pos(int out_w, int sw, int cw);
        return out_w + 2 * sw + cw;
    endfunction

    function automatic int uncond_pos(int out_w, int sw, int cw);
        return out_w + 2 * sw + cw + 1;
    endfunction

    function automatic int halt_pos(int out_w, int sw, int cw);
        return out_w + 2 * sw + cw + 2;
    endfunction

    function automatic int entry_w(int out_w, int sw, int cw);
        return out_w + 2 * sw + cw + 3;
    endfunction

    // Legacy graph: Y1 -> Y2 -> Y2Y3, which returns to Y2 when cond[0] is set.
    function automatic logic [MAX_E-1:0] default_entry(int i, int out_w, int sw, int cw);
        logic [MAX_E-1:0] e;
        e = '0;
        case (i)
            0: begin
                e[2:0] = Y1;
                e = e | (MAX_E'(1) << seq_lsb(out_w));
                e[uncond_pos(out_w, sw, cw)] = 1'b1;
            end
            1: begin
                e[2:0] = Y2;
                e = e | (MAX_E'(2) << seq_lsb(out_w));
                e[uncond_pos(out_w, sw, cw)] = 1'b1;
            end
            2: begin
                e[2:0] = Y23;
                e = e | (MAX_E'(1) << br_lsb(out_w, sw));
            end
            default: begin
                e[uncond_pos(out_w, sw, cw)] = 1'b1;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mi_sequencer_if.sv
// Control/status bundle of the microsequencer. The master drives step and
// configuration inputs; the slave (the sequencer) returns its current state.
interface mi_sequencer_if #(
    parameter int STATES = 8,
    parameter int OUT_W  = 8,
    parameter int COND_N = 4
);
    localparam int SW = $clog2(STATES);
    localparam int CW = $clog2(COND_N);
    localparam int E  = OUT_W + 2 * SW + CW + 3;

    // No ready path: en and start are level strobes sampled on every rising
    // edge, and cfg_we commits one entry per edge it is high.
    logic              en;
    logic              start;
    logic [COND_N-1:0] cond;
    logic              cfg_we;
    logic [SW-1:0]     cfg_addr;
    logic [E-1:0]      cfg_data;
    logic [OUT_W-1:0]  mi;
    logic [SW-1:0]     state;
    logic              halted;
    logic              err;
    logic [15:0]       step_cnt;

    modport master (
        output en, start, cond, cfg_we, cfg_addr, cfg_data,
        input  mi, state, halted, err, step_cnt
    );

    modport slave (
        input  en, start, cond, cfg_we, cfg_addr, cfg_data,
        output mi, state, halted, err, step_cnt
    );

endinterface

// File: rtl/mi_seq_table.sv
// Microinstruction table: one synchronous write port, one asynchronous read
// port, and every entry returns to the built-in graph on reset.
module mi_seq_table
    import mi_seq_pkg::*;
#(
    parameter int STATES = 8,
    parameter int OUT_W  = 8,
    parameter int COND_N = 4
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             we,
    input  logic [$clog2(STATES)-1:0]                        waddr,
    input  logic [OUT_W+2*$clog2(STATES)+$clog2(COND_N)+2:0] wdata,
    input  logic [$clog2(STATES)-1:0]                        raddr,
    output logic [OUT_W+2*$clog2(STATES)+$clog2(COND_N)+2:0] rdata
);
    localparam int SW = $clog2(STATES);
    localparam int CW = $clog2(COND_N);
    localparam int E  = entry_w(OUT_W, SW, CW);

    logic [E-1:0] mem [STATES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STATES; i++) begin
                mem[i] <= E'(default_entry(i, OUT_W, SW, CW));
            end
        end else if (we && (int'(waddr) < STATES)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < STATES) rdata = mem[raddr];
    end

endmodule

// File: rtl/mi_sequencer.sv
// Moore microsequencer: walks a programmable graph of microinstruction states,
// choosing each successor unconditionally or from one selected condition input.
module mi_sequencer
    import mi_seq_pkg::*;
#(
    parameter int STATES = 8,
    parameter int OUT_W  = 8,
    parameter int COND_N = 4
) (
    input  logic           clk,
    input  logic           reset,
    mi_sequencer_if.slave  bus
);
    localparam int SW       = $clog2(STATES);
    localparam int CW       = $clog2(COND_N);
    localparam int E        = entry_w(OUT_W, SW, CW);
    localparam int SEQ_LSB  = seq_lsb(OUT_W);
    localparam int BR_LSB   = br_lsb(OUT_W, SW);
    localparam int CSEL_LSB = csel_lsb(OUT_W, SW);
    localparam int INV_POS  = inv_pos(OUT_W, SW, CW);
    localparam int UNC_POS  = uncond_pos(OUT_W, SW, CW);
    localparam int HALT_POS = halt_pos(OUT_W, SW, CW);

    logic [E-1:0]  cur;
    logic [SW-1:0] state_q;
    logic          err_q;
    logic [15:0]   cnt_q;
    logic          cond_sel;
    logic          taken;
    logic [SW-1:0] nxt;
    seq_act_e      act;

    mi_seq_table #(
        .STATES (STATES),
        .OUT_W  (OUT_W),
        .COND_N (COND_N)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (bus.cfg_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (state_q),
        .rdata (cur)
    );

    // A csel beyond the populated inputs reads as a constant 0 condition.
    always_comb begin
        cond_sel = 1'b0;
        if (int'(cur[CSEL_LSB +: CW]) < COND_N) cond_sel = bus.cond[cur[CSEL_LSB +: CW]];
    end

    assign taken = cond_sel ^ cur[INV_POS];
    assign nxt   = (cur[UNC_POS] || !taken) ? cur[SEQ_LSB +: SW] : cur[BR_LSB +: SW];

    always_comb begin
        act = ACT_HOLD;
        if (bus.start)                        act = ACT_RESTART;
        else if (bus.en && !cur[HALT_POS])    act = ACT_STEP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (act)
                ACT_RESTART: begin
                    state_q <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                ACT_STEP: begin
                    // An out-of-range target parks at state 0 and latches err.
                    if (int'(nxt) < STATES) begin
                        state_q <= nxt;
                    end else begin
                        state_q <= '0;
                        err_q   <= 1'b1;
                    end
                    if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mi       = cur[OUT_W-1:0];
    assign bus.state    = state_q;
    assign bus.halted   = cur[HALT_POS];
    assign bus.err      = err_q;
    assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_mi_sequencer.sv
// Directed bench for mi_sequencer: an 8-state instance for the main graph
// tests and a 6-state instance for out-of-range transition targets.
module tb_mi_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mi_sequencer_if #(.STATES(8), .OUT_W(8), .COND_N(4)) bus_a ();
    mi_sequencer_if #(.STATES(6), .OUT_W(8), .COND_N(4)) bus_b ();

    mi_sequencer #(.STATES(8), .OUT_W(8), .COND_N(4)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mi_sequencer #(.STATES(6), .OUT_W(8), .COND_N(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] mk_entry(logic h, logic u, logic inv, logic [1:0] cs,
                                             logic [2:0] br, logic [2:0] sq, logic [7:0] m);
        return {h, u, inv, cs, br, sq, m};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_st [6];
    logic [7:0] exp_mi [6];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_a.en = 1'b0; bus_a.start = 1'b0; bus_a.cond = '0;
        bus_a.cfg_we = 1'b0; bus_a.cfg_addr = '0; bus_a.cfg_data = '0;
        bus_b.en = 1'b0; bus_b.start = 1'b0; bus_b.cond = '0;
        bus_b.cfg_we = 1'b0; bus_b.cfg_addr = '0; bus_b.cfg_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_state", 32'(bus_a.state), 32'd0);
        chk("rst_err", 32'(bus_a.err), 32'd0);
        chk("rst_cnt", 32'(bus_a.step_cnt), 32'd0);
        chk("rst_mi", 32'(bus_a.mi), 32'h04);
        chk("rst_halted", 32'(bus_a.halted), 32'd0);
        chk("rst_b_err", 32'(bus_b.err), 32'd0);

        // Default graph, cond[0]=0: 0,1,2,0,1,2
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        exp_mi = '{8'h04, 8'h02, 8'h03, 8'h04, 8'h02, 8'h03};
        bus_a.en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t1_state%0d", k), 32'(bus_a.state), 32'(exp_st[k]));
            chk($sformatf("t1_mi%0d", k), 32'(bus_a.mi), 32'(exp_mi[k]));
            tick();
        end
        chk("t1_cnt6", 32'(bus_a.step_cnt), 32'd6);
        chk("t1_state_end", 32'(bus_a.state), 32'd0);

        // Default graph, cond[0]=1: 0,1,2,1,2,1
        bus_a.cond  = 4'b0001;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("t2_start_cnt", 32'(bus_a.step_cnt), 32'd0);
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_state%0d", k), 32'(bus_a.state), 32'(exp_st[k]));
            tick();
        end
        chk("t2_err", 32'(bus_a.err), 32'd0);

        // Reprogram: 2 -> 3 unconditionally, 3 halts with mi A5
        bus_a.en       = 1'b0;
        bus_a.cond     = '0;
        bus_a.cfg_we   = 1'b1;
        bus_a.cfg_addr = 3'd2;
        bus_a.cfg_data = mk_entry(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 3'd3, 8'h03);
        tick();
        bus_a.cfg_addr = 3'd3;
        bus_a.cfg_data = mk_entry(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 8'hA5);
        tick();
        bus_a.cfg_we = 1'b0;
        bus_a.start  = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.en    = 1'b1;
        repeat (3) tick();
        chk("t3_state3", 32'(bus_a.state), 32'd3);
        chk("t3_mi_a5", 32'(bus_a.mi), 32'hA5);
        chk("t3_halted", 32'(bus_a.halted), 32'd1);
        chk("t3_cnt3", 32'(bus_a.step_cnt), 32'd3);
        repeat (3) tick();
        chk("t3_frozen_state", 32'(bus_a.state), 32'd3);
        chk("t3_frozen_cnt", 32'(bus_a.step_cnt), 32'd3);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("t3_restart_state", 32'(bus_a.state), 32'd0);
        chk("t3_restart_cnt", 32'(bus_a.step_cnt), 32'd0);
        chk("t3_restart_halted", 32'(bus_a.halted), 32'd0);

        // en low holds; start with en high restarts instead of advancing
        tick();
        chk("t4_step_state", 32'(bus_a.state), 32'd1);
        bus_a.en = 1'b0;
        repeat (5) tick();
        chk("t4_hold_state", 32'(bus_a.state), 32'd1);
        chk("t4_hold_cnt", 32'(bus_a.step_cnt), 32'd1);
        bus_a.en    = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("t4_start_state", 32'(bus_a.state), 32'd0);
        chk("t4_start_cnt", 32'(bus_a.step_cnt), 32'd0);

        // Write entry1 while stepping out of state 1: old entry wins
        tick();
        chk("t5_state1", 32'(bus_a.state), 32'd1);
        bus_a.cfg_we   = 1'b1;
        bus_a.cfg_addr = 3'd1;
        bus_a.cfg_data = mk_entry(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 8'h02);
        tick();
        bus_a.cfg_we = 1'b0;
        bus_a.en     = 1'b0;
        chk("t5_old_entry_state", 32'(bus_a.state), 32'd2);
        chk("t5_mi", 32'(bus_a.mi), 32'h03);

        // Asynchronous reset mid-run restores state 0 and the default table
        reset = 1'b1;
        #1;
        chk("t6_async_state", 32'(bus_a.state), 32'd0);
        chk("t6_async_mi", 32'(bus_a.mi), 32'h04);
        @(posedge clk);
        #1 reset = 1'b0;
        bus_a.en = 1'b1;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_default_state%0d", k), 32'(bus_a.state), 32'(exp_st[k]));
            if (k < 3) tick();
        end
        chk("t6_halted_clear", 32'(bus_a.halted), 32'd0);

        // Inverted branch on cond[1]: cond=0 -> taken -> br_next=5
        bus_a.en       = 1'b0;
        bus_a.cfg_we   = 1'b1;
        bus_a.cfg_addr = 3'd2;
        bus_a.cfg_data = mk_entry(1'b0, 1'b0, 1'b1, 2'd1, 3'd5, 3'd0, 8'h33);
        tick();
        bus_a.cfg_we = 1'b0;
        bus_a.en     = 1'b1;
        repeat (2) tick();
        chk("t7_state2", 32'(bus_a.state), 32'd2);
        chk("t7_mi33", 32'(bus_a.mi), 32'h33);
        tick();
        chk("t7_branch_state", 32'(bus_a.state), 32'd5);
        chk("t7_mi_default5", 32'(bus_a.mi), 32'h00);
        repeat (3) tick();
        bus_a.cond = 4'b0010;
        chk("t7_back_state2", 32'(bus_a.state), 32'd2);
        tick();
        chk("t7_not_taken", 32'(bus_a.state), 32'd0);
        chk("t7_err", 32'(bus_a.err), 32'd0);
        bus_a.en = 1'b0;

        // 6-state instance: target 6 is out of range
        bus_b.cfg_we   = 1'b1;
        bus_b.cfg_addr = 3'd0;
        bus_b.cfg_data = mk_entry(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 3'd6, 8'h11);
        tick();
        bus_b.cfg_we = 1'b0;
        chk("t8_err_pre", 32'(bus_b.err), 32'd0);
        bus_b.en = 1'b1;
        tick();
        chk("t8_oob_state", 32'(bus_b.state), 32'd0);
        chk("t8_oob_err", 32'(bus_b.err), 32'd1);
        chk("t8_oob_cnt", 32'(bus_b.step_cnt), 32'd1);
        tick();
        chk("t8_err_sticky", 32'(bus_b.err), 32'd1);
        chk("t8_cnt2", 32'(bus_b.step_cnt), 32'd2);
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        bus_b.en    = 1'b0;
        chk("t8_start_err", 32'(bus_b.err), 32'd0);
        chk("t8_start_cnt", 32'(bus_b.step_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mi_sequencer.md
# mi_sequencer

Parametrised Moore microsequencer for the control-automaton library. It steps through a run-time programmable graph of up to STATES microinstruction states. Each state emits a microinstruction word and picks its successor either unconditionally or from one of COND_N condition inputs. At reset it loads the built-in three-state graph (Y1 → Y2 → Y2Y3, branching on cond[0]), so it drops into existing designs unchanged.

## Interface
- STATES, 8: number of table entries, ≥3; SW = $clog2(STATES)
- OUT_W, 8: microinstruction width, ≥3
- COND_N, 4: condition inputs, ≥2; CW = $clog2(COND_N)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  step enable: advance one state per cycle while high
- start  in  1  synchronous restart to state 0; overrides en
- cond  in  COND_N  condition inputs, sampled at the step edge
- cfg_we  in  1  table write strobe
- cfg_addr  in  SW  entry index; writes with cfg_addr ≥ STATES are ignored
- cfg_data  in  E  entry, E = OUT_W+2*SW+CW+3; fields MSB→LSB: halt, uncond, inv, csel[CW], br_next[SW], seq_next[SW], mi[OUT_W]
- mi  out  OUT_W  microinstruction of the current state
- state  out  SW  current state index
- halted  out  1  current entry has halt=1
- err  out  1  sticky: a transition targeted an index ≥ STATES
- step_cnt  out  16  count of taken steps, saturating at 16'hFFFF

## Operation
- Reset values: state=0, err=0, step_cnt=0. The table is loaded with the default graph:
  - entry0: mi=3'b100, uncond, seq_next=1
  - entry1: mi=3'b010, uncond, seq_next=2
  - entry2: mi=3'b011, conditional, csel=0, inv=0, br_next=1, seq_next=0
  - all others: mi=0, uncond, seq_next=0, halt=0
  - mi values are zero-extended to OUT_W.
- Transition rule, for the current entry T:
  - taken = cond[T.csel] ^ T.inv
  - nxt = T.uncond ? T.seq_next : (taken ? T.br_next : T.seq_next)
- Step condition: a step occurs when en && !halted && !start.
  - state ← (nxt < STATES) ? nxt : 0
  - if nxt ≥ STATES, err ← 1
  - step_cnt increments, saturating at 16'hFFFF
- start: state ← 0, step_cnt ← 0, err ← 0. start overrides en and halted.
- halted is combinational from the current entry's halt bit. A halted sequencer leaves that state only via start, reset, or a cfg write that clears the halt bit.
- csel ≥ COND_N selects a constant 0 condition.
- A cfg write and a step in the same cycle: the step uses the pre-write entry, and the write lands on the same edge.
- Reset mid-run: state returns to 0 and the whole table reverts to its defaults.

## Timing
- state, err and step_cnt are registered and update on the rising clk edge.
- mi and halted are combinational from state and table contents: mi is valid in the cycle after the step edge, with no extra latency.
- A table write is visible on mi/halted the cycle after cfg_we if it targets the current state.
- cond must be stable around the step edge; there is no internal synchroniser.
- Reset is asynchronous assert. The caller must deassert it synchronously to clk.

## Structure
- Package mi_seq_pkg holds:
  - entry field offset/width functions of (OUT_W, SW, CW)
  - a default_entry(i) function that returns the default graph
  - the legacy constants Y1=3'b100, Y2=3'b010, Y23=3'b011
- Sub-module mi_seq_table: STATES×E register file with async reset to default_entry, one synchronous write port and one asynchronous read port.
- The top level holds the next-state logic, the state register, err and step_cnt.

## Test plan
- Reset, cond=0, en=1 → state 0,1,2,0,1,2; mi 4,2,3,4,2,3; step_cnt=6 after 6 cycles.
- cond[0]=1, en=1 → state 0,1,2,1,2,1; err stays 0.
- Program entry2 to uncond with seq_next=3, and entry3 with halt=1, mi=8'hA5 → state reaches 3, mi=8'hA5, halted=1. state and step_cnt then freeze with en high. start then gives state=0 and step_cnt=0.
- en=0 for 5 cycles → state and step_cnt hold. start=1 with en=1 → state=0, not an advance.
- STATES=6: write entry0 with uncond, seq_next=6 → next state=0, err=1, and err stays set until start.
- cfg write to entry1 (uncond, seq_next=0) in the same cycle as a step from state 1 → next state=2 (old entry). Assert reset while in state 2 → state=0 immediately and the default table is restored.
